// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// word capacity and header length width.
package instr_mem_loader_pkg;

    localparam int DEF_INS_MEM_DEPTH = 256;
    localparam int MAX_WORDS         = DEF_INS_MEM_DEPTH / 4;
    localparam int LEN_W             = 16;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } ldr_state_t;

endpackage

// File: rtl/instr_mem_loader_byte_to_word_packer.sv
// Collects four stream bytes MSB-first; word_valid flags the byte that
// completes a word, with word_next presenting the finished word that cycle.
module byte_to_word_packer #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word_next,
    output logic              word_valid
);

    // Only the first three bytes need storage; the fourth arrives live.
    logic [WORD_W-9:0] word_q;
    logic [1:0]        idx_q;

    assign word_next  = {word_q, byte_in};
    assign word_valid = shift_en && (idx_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (clr) begin
            idx_q  <= '0;
        end else if (shift_en) begin
            word_q <= word_next[WORD_W-9:0];
            idx_q  <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Writer side of instruction memory: parses a length-prefixed byte stream,
// writes 32-bit words at byte addresses 0,4,8,... and holds the CPU until done.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int Ins_mem_width = 32,
    parameter int Ins_mem_depth = DEF_INS_MEM_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_byte,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     reload,
    output logic                     wr_en,
    output logic [Ins_mem_width-1:0] wr_addr,
    output logic [Ins_mem_width-1:0] wr_data,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     err
);

    localparam int CAP_WORDS = Ins_mem_depth / 4;

    ldr_state_t               state_q, state_d;
    logic [7:0]               len_hi_q;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         len_full;
    logic [LEN_W-1:0]         wcnt_q;
    logic [Ins_mem_width-1:0] wr_addr_q, wr_data_q;
    logic [31:0]              word_next;
    logic                     word_valid;
    logic                     xfer, shift_en, pk_clr, reload_go;

    assign xfer      = in_valid && in_ready;
    assign shift_en  = xfer && (state_q == DATA);
    assign len_full  = {len_hi_q, in_byte};
    assign reload_go = reload && (state_q == DONE || state_q == ERR);

    byte_to_word_packer #(.WORD_W(32)) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (pk_clr),
        .shift_en   (shift_en),
        .byte_in    (in_byte),
        .word_next  (word_next),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= LEN_HI;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        pk_clr   = 1'b0;
        case (state_q)
            LEN_HI: begin
                in_ready = 1'b1;
                if (xfer) state_d = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                if (xfer) begin
                    if (len_full == '0)                     state_d = DONE;
                    else if (len_full > LEN_W'(CAP_WORDS))  state_d = ERR;
                    else                                    state_d = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (word_valid) state_d = WRITE;
            end
            WRITE: begin
                pk_clr  = 1'b1;
                state_d = (wcnt_q + LEN_W'(1) == len_q) ? DONE : DATA;
            end
            DONE, ERR: begin
                if (reload_go) begin
                    pk_clr  = 1'b1;
                    state_d = LEN_HI;
                end
            end
            default: state_d = LEN_HI;
        endcase
    end

    // Address/data are captured as the last byte lands so they are valid
    // throughout WRITE and hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_hi_q  <= '0;
            len_q     <= '0;
            wcnt_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            if (state_q == LEN_HI && xfer) len_hi_q <= in_byte;
            if (state_q == LEN_LO && xfer) len_q    <= len_full;
            if (word_valid) begin
                wr_data_q <= Ins_mem_width'(word_next);
                wr_addr_q <= Ins_mem_width'({wcnt_q, 2'b00});
            end
            if (state_q == WRITE) wcnt_q <= wcnt_q + LEN_W'(1);
            else if (reload_go)   wcnt_q <= '0;
        end
    end

    assign wr_en    = (state_q == WRITE);
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign done     = (state_q == DONE);
    assign err      = (state_q == ERR);
    assign cpu_hold = (state_q != DONE);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: cycle table for header/reload corners, then
// randomized images checked against a write-list model built from the image.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_byte;
    logic        in_valid, in_ready, reload;
    logic        wr_en, cpu_hold, done, err;
    logic [31:0] wr_addr, wr_data;

    instr_mem_loader dut (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .reload(reload), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t        got[$];
    wr_t        expq[$];
    logic [7:0] img[$];

    typedef struct packed {
        logic        v;
        logic [7:0]  b;
        logic        rl;
        logic        rdy, we, dn, er, hd;
        logic [31:0] a, d;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl[NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] b, input logic rl,
                                input logic rdy, input logic we, input logic dn,
                                input logic er, input logic [31:0] a, input logic [31:0] d);
        vec_t r;
        r = '{v: v, b: b, rl: rl, rdy: rdy, we: we, dn: dn, er: er, hd: ~dn, a: a, d: d};
        return r;
    endfunction

    // Every write seen by the memory; a byte must never be taken while writing.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_en === 1'b1) begin
            got.push_back('{wr_addr, wr_data});
            chk("ready_during_write", {31'b0, in_ready}, 32'd0);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; reload = 1'b0; in_byte = 8'h00;
        #1;
        chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_hold", {31'b0, cpu_hold}, 32'd1);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present a byte from a negedge until it is taken; returns at the negedge after.
    task automatic send_byte(input logic [7:0] b);
        logic r;
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        for (int k = 0; k < 50 && !ok; k++) begin
            r = in_ready;
            @(posedge clk);
            @(negedge clk);
            if (r) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: byte %h not accepted within 50 cycles", b);
        end
    endtask

    // Model: image = 16-bit count, then N big-endian words; word i goes to byte address 4*i.
    task automatic make_img(input int n, input int kind);
        logic [31:0] w;
        logic [15:0] n16;
        n16 = n[15:0];
        img.delete(); expq.delete();
        img.push_back(n16[15:8]);
        img.push_back(n16[7:0]);
        for (int i = 0; i < n; i++) begin
            w = (kind == 1) ? i : $urandom;
            img.push_back(w[31:24]); img.push_back(w[23:16]);
            img.push_back(w[15:8]);  img.push_back(w[7:0]);
            expq.push_back('{32'(4 * i), w});
        end
    endtask

    task automatic run_load(input string nm, input int max_gap);
        got.delete();
        for (int i = 0; i < img.size(); i++) begin
            if (max_gap > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, max_gap)) @(negedge clk);
            end
            send_byte(img[i]);
        end
        in_valid = 1'b0;
        if (expq.size() > 0) begin
            chk({nm, "_last_wr_en"}, {31'b0, wr_en}, 32'd1);
            @(negedge clk);
        end
        chk({nm, "_done"}, {31'b0, done}, 32'd1);
        chk({nm, "_hold"}, {31'b0, cpu_hold}, 32'd0);
        chk({nm, "_ready"}, {31'b0, in_ready}, 32'd0);
        chk({nm, "_nwrites"}, got.size(), expq.size());
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            chk($sformatf("%s_addr%0d", nm, i), got[i].a, expq[i].a);
            chk($sformatf("%s_data%0d", nm, i), got[i].d, expq[i].d);
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reload = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            v  byte   rl rdy we dn er  addr   data
        tbl[0]  = mk(1, 8'h00, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        tbl[1]  = mk(1, 8'h41, 0, 0, 0, 0, 1, 32'h0, 32'h0);
        tbl[2]  = mk(1, 8'h00, 0, 0, 0, 0, 1, 32'h0, 32'h0);
        tbl[3]  = mk(0, 8'h00, 1, 1, 0, 0, 0, 32'h0, 32'h0);
        tbl[4]  = mk(1, 8'h00, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        tbl[5]  = mk(1, 8'h01, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        tbl[6]  = mk(1, 8'h08, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        tbl[7]  = mk(1, 8'h00, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        tbl[8]  = mk(1, 8'h00, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        tbl[9]  = mk(1, 8'h11, 0, 0, 1, 0, 0, 32'h0, 32'h08000011);
        tbl[10] = mk(1, 8'h55, 0, 0, 0, 1, 0, 32'h0, 32'h08000011);
        tbl[11] = mk(1, 8'h55, 0, 0, 0, 1, 0, 32'h0, 32'h08000011);
        tbl[12] = mk(0, 8'h00, 1, 1, 0, 0, 0, 32'h0, 32'h08000011);
        tbl[13] = mk(1, 8'h00, 0, 1, 0, 0, 0, 32'h0, 32'h08000011);
        tbl[14] = mk(1, 8'h00, 0, 0, 0, 1, 0, 32'h0, 32'h08000011);
        tbl[15] = mk(0, 8'h00, 0, 0, 0, 1, 0, 32'h0, 32'h08000011);
        tbl[16] = mk(0, 8'h00, 1, 1, 0, 0, 0, 32'h0, 32'h08000011);
        tbl[17] = mk(1, 8'h00, 0, 1, 0, 0, 0, 32'h0, 32'h08000011);
        tbl[18] = mk(0, 8'h00, 1, 1, 0, 0, 0, 32'h0, 32'h08000011);
        tbl[19] = mk(1, 8'h02, 0, 1, 0, 0, 0, 32'h0, 32'h08000011);
        tbl[20] = mk(1, 8'hde, 0, 1, 0, 0, 0, 32'h0, 32'h08000011);
        tbl[21] = mk(1, 8'had, 0, 1, 0, 0, 0, 32'h0, 32'h08000011);
        tbl[22] = mk(1, 8'hbe, 0, 1, 0, 0, 0, 32'h0, 32'h08000011);
        tbl[23] = mk(1, 8'hef, 0, 0, 1, 0, 0, 32'h0, 32'hdeadbeef);
        tbl[24] = mk(0, 8'h00, 0, 1, 0, 0, 0, 32'h0, 32'hdeadbeef);

        rst_n = 1'b0; in_valid = 1'b0; reload = 1'b0; in_byte = 8'h00;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < NV; i++) begin
            in_valid = tbl[i].v;
            in_byte  = tbl[i].b;
            reload   = tbl[i].rl;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].rdy});
            chk($sformatf("tbl%0d_wr_en", i), {31'b0, wr_en},    {31'b0, tbl[i].we});
            chk($sformatf("tbl%0d_done", i),  {31'b0, done},     {31'b0, tbl[i].dn});
            chk($sformatf("tbl%0d_err", i),   {31'b0, err},      {31'b0, tbl[i].er});
            chk($sformatf("tbl%0d_hold", i),  {31'b0, cpu_hold}, {31'b0, tbl[i].hd});
            chk($sformatf("tbl%0d_addr", i),  wr_addr, tbl[i].a);
            chk($sformatf("tbl%0d_data", i),  wr_data, tbl[i].d);
        end
        in_valid = 1'b0; reload = 1'b0;

        // Three-word image, back to back and then with random gaps.
        for (int g = 0; g < 2; g++) begin
            do_reset();
            img = '{8'h00, 8'h03, 8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03,
                    8'h00, 8'h0c, 8'h20, 8'h67, 8'hff, 8'hf7};
            expq = '{'{32'h0, 32'h20020005}, '{32'h4, 32'h2003000c}, '{32'h8, 32'h2067fff7}};
            run_load(g == 0 ? "three" : "three_gap", g == 0 ? 0 : 5);
        end

        do_reset();
        make_img(0, 0);
        run_load("zero_len", 0);

        // Reset part-way through a word: no write, outputs cleared at once.
        do_reset();
        got.delete();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'hac); send_byte(8'h02);
        in_valid = 1'b0;
        #2;
        do_reset();
        chk("midrst_nwrites", got.size(), 32'd0);
        img  = '{8'h00, 8'h01, 8'hac, 8'h02, 8'h00, 8'h54};
        expq = '{'{32'h0, 32'hac020054}};
        run_load("after_midrst", 0);

        do_reset();
        make_img(64, 1);
        run_load("cap64", 1);
        if (got.size() > 0) begin
            chk("cap64_last_addr", got[got.size()-1].a, 32'h0000_00fc);
            chk("cap64_last_data", got[got.size()-1].d, 32'h0000_003f);
        end

        for (int t = 0; t < 6; t++) begin
            do_reset();
            make_img($urandom_range(1, 12), 0);
            run_load($sformatf("rand%0d", t), 5);
        end

        // Random over-capacity headers stick in ERR until reload.
        for (int t = 0; t < 4; t++) begin
            logic [15:0] n;
            do_reset();
            got.delete();
            n = 16'($urandom_range(65, 65535));
            send_byte(n[15:8]);
            send_byte(n[7:0]);
            in_valid = 1'b0;
            chk($sformatf("ovf%0d_err", t),   {31'b0, err},      32'd1);
            chk($sformatf("ovf%0d_hold", t),  {31'b0, cpu_hold}, 32'd1);
            chk($sformatf("ovf%0d_ready", t), {31'b0, in_ready}, 32'd0);
            in_valid = 1'b1; in_byte = 8'($urandom);
            repeat (3) @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("ovf%0d_err_sticky", t), {31'b0, err}, 32'd1);
            chk($sformatf("ovf%0d_nwrites", t), got.size(), 32'd0);
            pulse_reload();
            chk($sformatf("ovf%0d_err_clr", t), {31'b0, err},      32'd0);
            chk($sformatf("ovf%0d_ready1", t),  {31'b0, in_ready}, 32'd1);
            make_img($urandom_range(1, 4), 0);
            run_load($sformatf("ovf%0d_reload", t), 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
